l1_cache_ctrl: RTL and testbench
================================

Name: l1_cache_ctrl

Overview:
- Control and tag block for the direct-mapped L1 cache.
- It issues the index and write strobe that drive the 8-entry, 128-bit line data array.
- It answers the pipeline's memory requests, and fetches and evicts lines over the physical-memory port.
- Line-data muxing (CPU word merge vs. pmem line) sits in the cache datapath, selected by data_sel.

Parameters:
- TAG_W, 9, tag width (16-bit address = 9 tag + 3 index + 4 offset)
- SETS, 8, number of sets; fixed to match the data array depth

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_address  in  16  CPU byte address
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_resp  out  1  request complete (one-cycle pulse)
- data_index  out  3  set index to data array
- data_write  out  1  data array write strobe
- data_sel  out  1  write source: 0 = CPU merged line, 1 = pmem line
- pmem_address  out  16  line-aligned physical address
- pmem_read  out  1  line fill request; held until pmem_resp
- pmem_write  out  1  line eviction request; held until pmem_resp
- pmem_resp  in  1  physical memory done (one-cycle pulse)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high.
  - Reset forces state IDLE and clears all valid and dirty bits. Tags are don't-care.
- Output values in reset and IDLE-without-request: mem_resp=0, data_write=0, data_sel=0, pmem_read=0, pmem_write=0, data_index=mem_address[6:4], pmem_address=0.
- Address split: tag=addr[15:7], index=addr[6:4], offset=addr[3:0].
- Internal storage: valid[8], dirty[8], tag[8][TAG_W], all flops.
- Hit: valid[index] && tag[index]==addr tag, evaluated combinationally in IDLE.
- State IDLE:
  - No request: stay in IDLE.
  - Read hit: mem_resp=1 in the same cycle (data array read is asynchronous). Stay in IDLE.
  - Write hit: mem_resp=1, data_write=1, data_sel=0, and dirty[index] set at the clock edge. Stay in IDLE.
  - Miss with a clean or invalid victim: go to FILL.
  - Miss with a dirty valid victim: go to WRITEBACK.
  - mem_read and mem_write both high is illegal. Treat it as a write.
- State WRITEBACK:
  - pmem_write=1, pmem_address={tag[index], index, 4'b0}.
  - On pmem_resp: dirty[index] cleared, go to FILL.
- State FILL:
  - pmem_read=1, pmem_address={addr tag, index, 4'b0}.
  - On pmem_resp, in that same cycle: data_write=1, data_sel=1.
  - At the clock edge: tag[index]=addr tag, valid=1, dirty=0, go to IDLE.
- mem_resp is never asserted in WRITEBACK or FILL. The request is re-checked in IDLE and hits the cycle after the fill.
- Miss latency: 1 + pmem latency (+ writeback latency if the victim is dirty) + 1 hit cycle.
- The CPU must hold its address and request until mem_resp.
- Request dropped mid-miss: the in-flight pmem transaction still completes and the line is installed. The controller then returns to IDLE and issues no response.
- pmem_read and pmem_write are never high together.
- pmem_resp outside WRITEBACK/FILL is ignored.
- Reset mid-WRITEBACK or mid-FILL: next cycle is IDLE with pmem strobes low. The interrupted line is not installed.
- All sets start invalid, including set 0 with tag 0, so address 0x0000 misses after reset.

Test Plan:
- Cold read 0x1234 after reset:
  - FILL with pmem_address=0x1230 until pmem_resp.
  - data_write=1 and data_sel=1 in the pmem_resp cycle.
  - The next cycle hits with mem_resp=1.
- Write hit 0x1236 after that fill:
  - Same-cycle mem_resp=1, data_write=1, data_sel=0, data_index=3.
  - dirty[3]=1.
- Conflicting read 0x5230 (same index 3, dirty victim):
  - WRITEBACK with pmem_address=0x1230 and pmem_write=1.
  - Then FILL with pmem_address=0x5230.
  - Then a hit; pmem_read and pmem_write are never high together.
- Read miss on 0x0000 immediately after reset: must miss and fill (valid cleared), not false-hit on tag 0.
- Assert reset during FILL with pmem_resp withheld:
  - Next cycle: pmem_read=0, state IDLE.
  - Re-request of the same address misses again.
- Drop mem_read mid-FILL, then pulse pmem_resp:
  - Line is installed, no mem_resp.
  - A later read of the same line hits in 1 cycle.

Source files
------------

// File: rtl/l1_cache_ctrl_if.sv
// CPU, data-array and physical-memory signals of the L1 cache controller.
// The controller takes the slave view; the requester/memory side takes the master view.
interface l1_cache_ctrl_if;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic        mem_resp;
  logic [2:0]  data_index;
  logic        data_write;
  logic        data_sel;
  logic [15:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_resp;

  modport master (
    output mem_address, mem_read, mem_write, pmem_resp,
    input  mem_resp, data_index, data_write, data_sel,
           pmem_address, pmem_read, pmem_write
  );

  modport slave (
    input  mem_address, mem_read, mem_write, pmem_resp,
    output mem_resp, data_index, data_write, data_sel,
           pmem_address, pmem_read, pmem_write
  );
endinterface

// File: rtl/l1_cache_ctrl.sv
// Tag/valid/dirty store and miss-handling FSM for the direct-mapped L1 cache.
// Hits answer in IDLE; misses optionally write back the victim, then fill.
module l1_cache_ctrl #(
  parameter int TAG_W = 9,
  parameter int SETS  = 8
) (
  input logic           clk,
  input logic           reset,
  l1_cache_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = 16 - TAG_W - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t           state, next_state;
  logic [SETS-1:0]  valid, dirty;
  logic [TAG_W-1:0] tags [SETS];
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic [IDX_W-1:0] req_idx, miss_idx;
  logic             req, hit;

  assign req_tag = bus.mem_address[15 -: TAG_W];
  assign req_idx = bus.mem_address[OFF_W +: IDX_W];
  assign req     = bus.mem_read | bus.mem_write;
  assign hit     = valid[req_idx] && (tags[req_idx] == req_tag);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE:      if (req && hit && bus.mem_write) dirty[req_idx] <= 1'b1;
        WRITEBACK: if (bus.pmem_resp) dirty[miss_idx] <= 1'b0;
        FILL: begin
          if (bus.pmem_resp) begin
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // The miss line is latched so a dropped request still installs the right line.
  always_ff @(posedge clk) begin
    if (state == IDLE && req && !hit) begin
      miss_tag <= req_tag;
      miss_idx <= req_idx;
    end
    if (!reset && state == FILL && bus.pmem_resp) tags[miss_idx] <= miss_tag;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          if (valid[req_idx] && dirty[req_idx]) next_state = WRITEBACK;
          else                                  next_state = FILL;
        end
      end
      WRITEBACK: if (bus.pmem_resp) next_state = FILL;
      FILL:      if (bus.pmem_resp) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_resp     = 1'b0;
    bus.data_write   = 1'b0;
    bus.data_sel     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.data_index   = req_idx;
    bus.pmem_address = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            bus.mem_resp   = 1'b1;
            bus.data_write = bus.mem_write;
          end
        end
        WRITEBACK: begin
          bus.data_index   = miss_idx;
          bus.pmem_write   = 1'b1;
          bus.pmem_address = {tags[miss_idx], miss_idx, {OFF_W{1'b0}}};
        end
        FILL: begin
          bus.data_index   = miss_idx;
          bus.pmem_read    = 1'b1;
          bus.pmem_address = {miss_tag, miss_idx, {OFF_W{1'b0}}};
          if (bus.pmem_resp) begin
            bus.data_write = 1'b1;
            bus.data_sel   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Scoreboard bench for l1_cache_ctrl: a line-level cache model predicts each
// response, a random-latency memory answers pmem, and a monitor checks responses.
module tb_l1_cache_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic hold = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  l1_cache_ctrl_if bus();

  l1_cache_ctrl #(.TAG_W(9), .SETS(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic        write;
    logic        hit;
    logic        wb;
    logic [15:0] wb_addr;
    logic [15:0] fill_addr;
  } exp_t;

  exp_t sbq[$];
  bit   m_valid[8];
  bit   m_dirty[8];
  int   m_tag[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = 0;
    end
  endfunction

  function automatic bit modelHit(input logic [15:0] addr);
    int line = int'(addr) / 16;
    return m_valid[line % 8] && (m_tag[line % 8] == line / 8);
  endfunction

  function automatic bit modelCleanMiss(input logic [15:0] addr);
    int line = int'(addr) / 16;
    return !modelHit(addr) && !(m_valid[line % 8] && m_dirty[line % 8]);
  endfunction

  // Memory lines map to set = line mod 8, tag = line div 8.
  function automatic exp_t predictAndUpdate(input logic [15:0] addr, input logic write);
    exp_t e;
    int line, s, t;
    line = int'(addr) / 16;
    s = line % 8;
    t = line / 8;
    e.addr      = addr;
    e.write     = write;
    e.hit       = m_valid[s] && (m_tag[s] == t);
    e.wb        = !e.hit && m_valid[s] && m_dirty[s];
    e.wb_addr   = 16'((m_tag[s] * 8 + s) * 16);
    e.fill_addr = 16'(line * 16);
    if (!e.hit) begin
      m_valid[s] = 1;
      m_tag[s]   = t;
      m_dirty[s] = 0;
    end
    if (write) m_dirty[s] = 1;
    return e;
  endfunction

  task automatic doReset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    hold  = 1'b0;
    modelReset();
    sbq.delete();
  endtask

  // mode 0: normal request; 1: read dropped during FILL; 2: reset during a stalled FILL.
  task automatic applyStimulus(input logic [15:0] addr, input logic write, input int mode);
    exp_t e;
    bit done = 0;
    @(posedge clk); #1;
    if (mode == 2) hold = 1'b1;
    if (mode == 0) begin
      e = predictAndUpdate(addr, write);
      sbq.push_back(e);
    end else if (mode == 1) begin
      e = predictAndUpdate(addr, 1'b0);
    end
    bus.mem_address = addr;
    bus.mem_write   = (mode == 0) ? write : 1'b0;
    bus.mem_read    = (mode == 0) ? !write : 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (mode == 0) done = bus.mem_resp;
      else           done = bus.pmem_read;
    end
    if (!done) begin
      checkOutput("request_timeout", 0, 1);
      doReset();
      return;
    end
    if (mode == 2) repeat (2) @(negedge clk);
    @(posedge clk); #1;
    if (mode == 2) reset = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (mode == 1) begin
      done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
        @(negedge clk);
        done = !bus.pmem_read && !bus.pmem_write;
      end
      checkOutput("dropped_fill_completes", done, 1);
    end else if (mode == 2) begin
      @(posedge clk); #1;
      reset = 1'b0;
      hold  = 1'b0;
      modelReset();
      @(negedge clk);
      checkOutput("abort_pmem_read", bus.pmem_read, 0);
      checkOutput("abort_pmem_write", bus.pmem_write, 0);
    end
  endtask

  // Physical memory: answers any strobe after 0-3 extra cycles, one-cycle pulse.
  initial begin
    int lat = 0;
    bus.pmem_resp = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.pmem_resp || reset || hold) bus.pmem_resp = 1'b0;
      else if (bus.pmem_read || bus.pmem_write) begin
        if (lat == 0) begin
          bus.pmem_resp = 1'b1;
          lat = $urandom_range(0, 3);
        end else lat--;
      end
    end
  end

  // Monitor: gathers pmem activity per request and scores each mem_resp.
  initial begin
    int          cyc = 0;
    bit          obs_wb = 0, obs_fill = 0, prev_fill = 0;
    logic [15:0] obs_wb_addr = '0, obs_fill_addr = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0; obs_wb = 0; obs_fill = 0; prev_fill = 0;
      end else begin
        if (bus.pmem_read || bus.pmem_write)
          checkOutput("pmem_rd_wr_overlap", bus.pmem_read & bus.pmem_write, 0);
        if (bus.pmem_resp && bus.pmem_read) begin
          checkOutput("fill_data_write", bus.data_write, 1);
          checkOutput("fill_data_sel", bus.data_sel, 1);
        end
        if (bus.mem_read || bus.mem_write) begin
          cyc++;
          if (prev_fill) checkOutput("hit_after_fill", bus.mem_resp, 1);
          prev_fill = 0;
          if (bus.pmem_resp && bus.pmem_write) begin
            obs_wb = 1; obs_wb_addr = bus.pmem_address;
          end
          if (bus.pmem_resp && bus.pmem_read) begin
            obs_fill = 1; obs_fill_addr = bus.pmem_address; prev_fill = 1;
          end
          if (bus.mem_resp) begin
            if (sbq.size() == 0) checkOutput("unexpected_resp", 1, 0);
            else begin
              e = sbq.pop_front();
              checkOutput("resp_index", bus.data_index, e.addr[6:4]);
              checkOutput("resp_data_write", bus.data_write, e.write);
              checkOutput("resp_data_sel", bus.data_sel, 0);
              checkOutput("resp_writeback", obs_wb, e.wb);
              if (e.wb) checkOutput("writeback_addr", obs_wb_addr, e.wb_addr);
              checkOutput("resp_fill", obs_fill, !e.hit);
              if (!e.hit) checkOutput("fill_addr", obs_fill_addr, e.fill_addr);
              if (e.hit) checkOutput("hit_latency", cyc, 1);
            end
            cyc = 0; obs_wb = 0; obs_fill = 0;
          end
        end else begin
          checkOutput("resp_without_request", bus.mem_resp, 0);
          cyc = 0; obs_wb = 0; obs_fill = 0; prev_fill = 0;
        end
      end
    end
  end

  initial begin
    logic [15:0] a;
    int          r, mode;
    reset = 1'b1;
    bus.mem_address = 16'h0050;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_mem_resp", bus.mem_resp, 0);
    checkOutput("reset_data_write", bus.data_write, 0);
    checkOutput("reset_data_sel", bus.data_sel, 0);
    checkOutput("reset_pmem_read", bus.pmem_read, 0);
    checkOutput("reset_pmem_write", bus.pmem_write, 0);
    checkOutput("reset_pmem_address", bus.pmem_address, 0);
    checkOutput("reset_data_index", bus.data_index, 5);
    @(posedge clk); #1;
    reset = 1'b0;

    applyStimulus(16'h0000, 1'b0, 0);
    applyStimulus(16'h1234, 1'b0, 0);
    applyStimulus(16'h1236, 1'b1, 0);
    applyStimulus(16'h5230, 1'b0, 0);
    applyStimulus(16'h7040, 1'b0, 1);
    applyStimulus(16'h7048, 1'b0, 0);
    applyStimulus(16'h2220, 1'b0, 0);
    applyStimulus(16'h3330, 1'b0, 2);
    applyStimulus(16'h3330, 1'b0, 0);
    applyStimulus(16'h2220, 1'b1, 0);

    for (int n = 0; n < 300; n++) begin
      a = 16'($urandom_range(0, 4) * 128 + $urandom_range(0, 7) * 16 + $urandom_range(0, 15));
      if (a[15:7] == 9'd4) a[15:7] = 9'h1ff;
      r = $urandom_range(0, 19);
      mode = 0;
      if (r == 0 && !modelHit(a)) mode = 1;
      if (r == 1 && modelCleanMiss(a)) mode = 2;
      applyStimulus(a, 1'($urandom_range(0, 1)), mode);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
